axi_master_arbiter: RTL
=======================

Name: axi_master_arbiter

Overview:
- Shares the single `io_master` AXI4 master port between two requesters: IFU (read only) and LSU (read or write).
- Each transaction is single-beat only.
- Upstream interfaces are simple valid/ready request ports with a one-cycle response pulse.
- Sits between the core front-end/LSU and the SoC AXI crossbar. It replaces per-unit state sequencing with one central arbiter and sequencer.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- IFU_ID, 4'd0, AXI ID driven on IFU reads
- LSU_ID, 4'd1, AXI ID driven on LSU reads and writes

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  request accepted (1-cycle pulse)
- ifu_addr  in  ADDR_W  fetch address
- ifu_resp_valid  out  1  fetch data valid (1-cycle pulse)
- ifu_rdata  out  DATA_W  fetched word
- ifu_resp_err  out  1  rresp != OKAY
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  request accepted (1-cycle pulse)
- lsu_we  in  1  1 = write, 0 = read
- lsu_addr  in  ADDR_W  access address
- lsu_size  in  3  AXI size encoding (0/1/2)
- lsu_wdata  in  DATA_W  lane-aligned write data
- lsu_wstrb  in  4  lane-aligned byte strobes
- lsu_resp_valid  out  1  read data or write ack (1-cycle pulse)
- lsu_rdata  out  DATA_W  raw read beat
- lsu_resp_err  out  1  rresp/bresp != OKAY
- io_master_aw*  AW channel: valid/addr/id/len/size/burst out, ready in
- io_master_w*  W channel: valid/data/strb/last out, ready in
- io_master_b*  B channel: ready out, valid/resp/id in
- io_master_ar*  AR channel: valid/addr/id/len/size/burst out, ready in
- io_master_r*  R channel: ready out, valid/resp/data/last/id in

Behaviour:
- Reset: state IDLE; all valid/ready/pulse outputs 0; captured registers 0; last_grant = LSU, so IFU wins the first tie.
- States:
  - IDLE: arbitrate among asserted requests. The winner's req_ready pulses in the same cycle. Addr/we/size/wdata/wstrb/ID are captured on that edge. Next state is RD_AR for reads or WR_AW for writes. No request keeps the block in IDLE.
  - RD_AR: arvalid=1, araddr/arsize held from the capture. On arready, go to RD_R.
  - RD_R: rready=1. On rvalid, rdata/err go to the owner, the owner's resp_valid pulses for 1 cycle, and the next state is IDLE.
  - WR_AW: awvalid=1 and wvalid=1 together. Per-channel done flags are set on each handshake. When both are done (same cycle allowed), go to WR_B.
  - WR_B: bready=1. On bvalid, pulse lsu_resp_valid with err = bresp[1]; next state is IDLE.
- Fixed field values: len=0, burst=INCR (2'b01), wlast=wvalid. IFU size=2.
- Latency: request to AR is 1 cycle. Best case request to response is 3 cycles (zero-wait slave).
- A request is accepted only in IDLE. There is at most one outstanding transaction.
- Outputs stay stable while valid is high and unacknowledged; AXI rule: no withdrawal.
- Response ownership is the captured grant, not rid/bid. A mismatched ID does not change routing; it only sets resp_err for the response.
- Simultaneous IFU and LSU requests are resolved by the arbitration policy (see Optional Feature).
- A requester that drops valid before its ready pulse is simply not serviced.
- Reset mid-transaction returns to IDLE immediately. The bus side must be reset together.
- Alignment and splitting of misaligned accesses are the requester's job; the arbiter forwards fields unchanged.

Optional Feature:
- Macro: AXI_ARB_ROUND_ROBIN_EN
- Defined: on a tie, the requester not granted last wins. last_grant updates on every grant.
- Undefined: fixed priority, LSU always wins ties. last_grant is unused.

Decomposition:
- Package axi_arb_pkg holds:
  - state enum: IDLE, RD_AR, RD_R, WR_AW, WR_B
  - BURST_INCR, RESP_OKAY, SIZE_B/H/W constants
  - owner enum: OWN_IFU, OWN_LSU
- One sub-module, arb_pick2: combinational 2-way picker taking req[1:0] and last_grant, producing a grant one-hot. It is instantiated once.

Test Plan:
- IFU request at 0x8000_0000, zero-wait slave returns 0x0000_0413 → araddr=0x8000_0000, arid=0; ifu_resp_valid pulses on the 3rd cycle with rdata=0x0000_0413.
- LSU write addr 0x8000_0104, wdata=0xDEAD_BEEF, wstrb=0xF; slave gives awready 2 cycles before wready → exactly one AW and one W handshake; lsu_resp_valid pulses once after bvalid.
- IFU and LSU requesting together, repeated 4 times → with the macro, grants alternate IFU, LSU, IFU, LSU; without it, LSU wins all 4 while IFU is held off until LSU drops.
- Read with rresp=2'b10 → lsu_resp_err=1 and rdata is still forwarded. Then bresp=2'b11 on a write → lsu_resp_err=1.
- Slave holds arready=0 for 10 cycles → arvalid and araddr stay constant for all 10 cycles; a new ifu_req_valid gets no ready pulse in that time.
- Assert reset during RD_R → all valids drop asynchronously, the next state is IDLE, and no resp_valid pulse is emitted.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the single-beat AXI master arbiter.
package axi_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD_AR = 3'd1,
      RD_R  = 3'd2,
      WR_AW = 3'd3,
      WR_B  = 3'd4
   } state_e;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [2:0] SIZE_B     = 3'd0;
   localparam logic [2:0] SIZE_H     = 3'd1;
   localparam logic [2:0] SIZE_W     = 3'd2;

endpackage

// File: rtl/arb_pick2.sv
// Two-way request picker: bit 0 = IFU, bit 1 = LSU, one-hot grant out.
// AXI_ARB_ROUND_ROBIN_EN: ties go to the requester not granted last; otherwise LSU wins ties.
module arb_pick2
   import axi_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  owner_e     last_grant_i,
   output logic [1:0] gnt_o
);

   // Grant selection, only a tie consults the policy
   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11: begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
            if (last_grant_i == OWN_LSU) begin
               gnt_o = 2'b01;
            end else begin
               gnt_o = 2'b10;
            end
`else
            gnt_o = 2'b10;
`endif
         end
         default: gnt_o = 2'b00;
      endcase
   end

`ifndef AXI_ARB_ROUND_ROBIN_EN
   logic unused_last_grant_s;
   assign unused_last_grant_s = last_grant_i;
`endif

endmodule

// File: rtl/axi_master_arbiter.sv
// Shares one AXI4 master port between IFU (reads) and LSU (reads/writes), one single-beat txn at a time.
// Tie-break policy set by AXI_ARB_ROUND_ROBIN_EN (round robin) or fixed LSU priority when undefined.
module axi_master_arbiter
   import axi_arb_pkg::*;
#(
   parameter int         ADDR_W = 32,
   parameter int         DATA_W = 32,
   parameter logic [3:0] IFU_ID = 4'd0,
   parameter logic [3:0] LSU_ID = 4'd1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_resp_err,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_we,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [2:0]        lsu_size,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [3:0]        lsu_wstrb,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_resp_err,
   output logic              io_master_awvalid,
   output logic [ADDR_W-1:0] io_master_awaddr,
   output logic [3:0]        io_master_awid,
   output logic [7:0]        io_master_awlen,
   output logic [2:0]        io_master_awsize,
   output logic [1:0]        io_master_awburst,
   input  logic              io_master_awready,
   output logic              io_master_wvalid,
   output logic [DATA_W-1:0] io_master_wdata,
   output logic [3:0]        io_master_wstrb,
   output logic              io_master_wlast,
   input  logic              io_master_wready,
   output logic              io_master_bready,
   input  logic              io_master_bvalid,
   input  logic [1:0]        io_master_bresp,
   input  logic [3:0]        io_master_bid,
   output logic              io_master_arvalid,
   output logic [ADDR_W-1:0] io_master_araddr,
   output logic [3:0]        io_master_arid,
   output logic [7:0]        io_master_arlen,
   output logic [2:0]        io_master_arsize,
   output logic [1:0]        io_master_arburst,
   input  logic              io_master_arready,
   output logic              io_master_rready,
   input  logic              io_master_rvalid,
   input  logic [1:0]        io_master_rresp,
   input  logic [DATA_W-1:0] io_master_rdata,
   input  logic              io_master_rlast,
   input  logic [3:0]        io_master_rid
);

   state_e            state_q;
   owner_e            owner_q;
   owner_e            last_grant_q;
   logic [ADDR_W-1:0] addr_q;
   logic [2:0]        size_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        wstrb_q;
   logic [3:0]        id_q;
   logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic              ifu_resp_valid_q, lsu_resp_valid_q, err_q;
   logic [1:0]        req_s, gnt_s;
   logic              aw_done_s, w_done_s;
   logic              unused_rlast_s;

   // Requests are only considered in IDLE so a grant can never overlap a live transaction
   assign req_s = (state_q == IDLE && !reset) ? {lsu_req_valid, ifu_req_valid} : 2'b00;

   arb_pick2 u_pick (
      .req_i        (req_s),
      .last_grant_i (last_grant_q),
      .gnt_o        (gnt_s)
   );

   assign ifu_req_ready = gnt_s[0];
   assign lsu_req_ready = gnt_s[1];

   // A channel counts as done once its valid has dropped or it handshakes this cycle
   assign aw_done_s = !awvalid_q || io_master_awready;
   assign w_done_s  = !wvalid_q  || io_master_wready;

   // Transaction sequencer: capture on grant, drive one channel phase at a time
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         owner_q          <= OWN_IFU;
         last_grant_q     <= OWN_LSU;
         addr_q           <= '0;
         size_q           <= 3'd0;
         wdata_q          <= '0;
         rdata_q          <= '0;
         wstrb_q          <= 4'd0;
         id_q             <= 4'd0;
         arvalid_q        <= 1'b0;
         rready_q         <= 1'b0;
         awvalid_q        <= 1'b0;
         wvalid_q         <= 1'b0;
         bready_q         <= 1'b0;
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         err_q            <= 1'b0;
      end else begin
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_s[0]) begin
                  addr_q       <= ifu_addr;
                  size_q       <= SIZE_W;
                  id_q         <= IFU_ID;
                  owner_q      <= OWN_IFU;
                  last_grant_q <= OWN_IFU;
                  arvalid_q    <= 1'b1;
                  state_q      <= RD_AR;
               end else if (gnt_s[1]) begin
                  addr_q       <= lsu_addr;
                  size_q       <= lsu_size;
                  wdata_q      <= lsu_wdata;
                  wstrb_q      <= lsu_wstrb;
                  id_q         <= LSU_ID;
                  owner_q      <= OWN_LSU;
                  last_grant_q <= OWN_LSU;
                  if (lsu_we) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR_AW;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_AR;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            RD_AR: begin
               if (io_master_arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_R;
               end else begin
                  state_q <= RD_AR;
               end
            end
            RD_R: begin
               if (io_master_rvalid) begin
                  rready_q <= 1'b0;
                  rdata_q  <= io_master_rdata;
                  // Routing follows the captured owner; a foreign rid only flags an error
                  err_q    <= (io_master_rresp != RESP_OKAY) || (io_master_rid != id_q);
                  if (owner_q == OWN_IFU) begin
                     ifu_resp_valid_q <= 1'b1;
                  end else begin
                     lsu_resp_valid_q <= 1'b1;
                  end
                  state_q <= IDLE;
               end else begin
                  state_q <= RD_R;
               end
            end
            WR_AW: begin
               if (io_master_awready) begin
                  awvalid_q <= 1'b0;
               end else begin
                  awvalid_q <= awvalid_q;
               end
               if (io_master_wready) begin
                  wvalid_q <= 1'b0;
               end else begin
                  wvalid_q <= wvalid_q;
               end
               if (aw_done_s && w_done_s) begin
                  bready_q <= 1'b1;
                  state_q  <= WR_B;
               end else begin
                  state_q <= WR_AW;
               end
            end
            WR_B: begin
               if (io_master_bvalid) begin
                  bready_q         <= 1'b0;
                  err_q            <= io_master_bresp[1] || (io_master_bid != id_q);
                  lsu_resp_valid_q <= 1'b1;
                  state_q          <= IDLE;
               end else begin
                  state_q <= WR_B;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign io_master_arvalid = arvalid_q;
   assign io_master_araddr  = addr_q;
   assign io_master_arid    = id_q;
   assign io_master_arlen   = 8'd0;
   assign io_master_arsize  = size_q;
   assign io_master_arburst = BURST_INCR;
   assign io_master_rready  = rready_q;
   assign io_master_awvalid = awvalid_q;
   assign io_master_awaddr  = addr_q;
   assign io_master_awid    = id_q;
   assign io_master_awlen   = 8'd0;
   assign io_master_awsize  = size_q;
   assign io_master_awburst = BURST_INCR;
   assign io_master_wvalid  = wvalid_q;
   assign io_master_wdata   = wdata_q;
   assign io_master_wstrb   = wstrb_q;
   assign io_master_wlast   = wvalid_q;
   assign io_master_bready  = bready_q;

   assign ifu_resp_valid = ifu_resp_valid_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign ifu_rdata      = rdata_q;
   assign lsu_rdata      = rdata_q;
   assign ifu_resp_err   = err_q;
   assign lsu_resp_err   = err_q;

   assign unused_rlast_s = io_master_rlast;

endmodule
